// File: rtl/rv32i_types.sv
// Shared types and sizing for the ALU writeback path.
package rv32i_types;

   localparam int unsigned alu_rs_size       = 8;
   localparam int unsigned alu_rs_index_bits = $clog2(alu_rs_size);
   localparam int unsigned rob_size          = 16;
   localparam int unsigned rob_index_bits    = $clog2(rob_size);
   localparam int unsigned wbq_size          = 16;
   localparam int unsigned wbq_index_bits    = $clog2(wbq_size);

   typedef struct packed {
      logic [rob_index_bits-1:0] rob_idx;
      logic [31:0]               data;
   } alu_wb_entry_t;

   // Number of set bits in an RS-wide mask.
   function automatic logic [alu_rs_index_bits:0] popcount(input logic [alu_rs_size-1:0] v);
      logic [alu_rs_index_bits:0] n;
      n = '0;
      for (int i = 0; i < alu_rs_size; i++) begin
         n = n + {{alu_rs_index_bits{1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/multi_enq_ring.sv
// Circular buffer with N-wide compacting enqueue, single dequeue and flush.
module multi_enq_ring
   import rv32i_types::*;
#(
   parameter int unsigned n_enq    = alu_rs_size,
   parameter int unsigned depth    = wbq_size,
   parameter int unsigned idx_bits = wbq_index_bits
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [n_enq-1:0]    enq_valid,
   input  alu_wb_entry_t [n_enq-1:0] enq_data,
   input  logic                deq,
   output logic                head_valid,
   output alu_wb_entry_t       head_data,
   output logic [idx_bits:0]   count
);

   alu_wb_entry_t        mem_q [depth];
   alu_wb_entry_t        mem_d [depth];
   logic [idx_bits-1:0]  head_q, head_d, tail_q, wr_ptr;
   logic [idx_bits:0]    count_q, count_d, enq_cnt;
   logic                 deq_ok;

   // Pack valid enqueue lanes into consecutive slots starting at tail, lowest lane first.
   always_comb begin
      mem_d   = mem_q;
      wr_ptr  = tail_q;
      enq_cnt = '0;
      for (int i = 0; i < n_enq; i++) begin
         if (enq_valid[i]) begin
            mem_d[wr_ptr] = enq_data[i];
            wr_ptr        = wr_ptr + idx_bits'(1);
            enq_cnt       = enq_cnt + (idx_bits + 1)'(1);
         end
      end
   end

   // Pointer and occupancy next state; a pop only happens when there is a head.
   always_comb begin
      deq_ok  = deq && head_valid;
      head_d  = head_q + idx_bits'(deq_ok);
      count_d = count_q + enq_cnt - (idx_bits + 1)'(deq_ok);
   end

   // State update: reset clears storage too so the head reads as zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         mem_q   <= '{default: '0};
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= wr_ptr;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign head_valid = (count_q != '0);
   assign head_data  = mem_q[head_q];
   assign count      = count_q;

   // Upstream stall logic must keep occupancy within the ring.
   assert property (@(posedge clk) disable iff (rst || flush)
                    count_d <= (idx_bits + 1)'(depth));

endmodule

// File: rtl/alu_writeback_queue.sv
// Captures completed ALU results by RS slot and drains them to the ROB in order.
module alu_writeback_queue
   import rv32i_types::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_alurs_dec,
   input  logic [alu_rs_index_bits-1:0] widx_alurs,
   input  logic [rob_index_bits-1:0]    rob_tag_dec,
   input  logic [alu_rs_size-1:0]       done_alurs,
   input  logic [32*alu_rs_size-1:0]    data_alurs,
   input  logic                         flush,
   input  logic                         rob_wr_ready,
   output logic                         rob_wr_valid,
   output logic [rob_index_bits-1:0]    rob_wr_idx,
   output logic [31:0]                  rob_wr_data,
   output logic                         wbq_stall
);

   logic [rob_index_bits-1:0]   tag_q [alu_rs_size];
   logic [rob_index_bits-1:0]   tag_d [alu_rs_size];
   logic [alu_rs_size-1:0]      tag_valid_q, tag_valid_d, capture;
   alu_wb_entry_t [alu_rs_size-1:0] enq_data;
   alu_wb_entry_t               head_data;
   logic [wbq_index_bits:0]     count;
   logic [wbq_index_bits+1:0]   occupancy;

   // done_alurs stays high after completion, so tag_valid alone dedupes captures.
   assign capture = done_alurs & tag_valid_q;

   // Pair each slot's tracked tag with its result lane.
   always_comb begin
      for (int j = 0; j < alu_rs_size; j++) begin
         enq_data[j].rob_idx = tag_q[j];
         enq_data[j].data    = data_alurs[32*j +: 32];
      end
   end

   // Captured slots stop being tracked; a same-cycle load re-arms the slot with the new tag.
   always_comb begin
      tag_d       = tag_q;
      tag_valid_d = tag_valid_q & ~capture;
      if (load_alurs_dec) begin
         tag_d[widx_alurs]       = rob_tag_dec;
         tag_valid_d[widx_alurs] = 1'b1;
      end
   end

   // Slot tag tracking; flush drops same-cycle loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q       <= '{default: '0};
         tag_valid_q <= '0;
      end else if (flush) begin
         tag_valid_q <= '0;
      end else begin
         tag_q       <= tag_d;
         tag_valid_q <= tag_valid_d;
      end
   end

   multi_enq_ring #(
      .n_enq    (alu_rs_size),
      .depth    (wbq_size),
      .idx_bits (wbq_index_bits)
   ) u_ring (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .enq_valid  (capture),
      .enq_data   (enq_data),
      .deq        (rob_wr_valid && rob_wr_ready),
      .head_valid (rob_wr_valid),
      .head_data  (head_data),
      .count      (count)
   );

   assign rob_wr_idx  = head_data.rob_idx;
   assign rob_wr_data = head_data.data;

   // Reserve a queue entry for every tracked slot so enqueue can never overflow.
   always_comb begin
      occupancy = {1'b0, count} + (wbq_index_bits + 2)'(popcount(tag_valid_q));
      wbq_stall = (occupancy >= (wbq_index_bits + 2)'(wbq_size));
   end

endmodule
